// File: rtl/control_sequencer.sv
// control_sequencer
//   Instruction-cycle sequencer: owns the FETCH/DECODE/EXECUTE/WRITEBACK/HALT
//   state machine and the instruction register, and drives the datapath
//   control word every cycle.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   instr_in        instruction from memory
//   instr_valid     instr_in is valid this cycle
//   stall           freeze the sequencer (ignored in HALT)
//   mem_ready       LOAD data available
//   control_signals datapath control word, combinational from state/IR
//   state           0=FETCH 1=DECODE 2=EXECUTE 3=WRITEBACK 4=HALT
//   instr_reg       latched instruction
//   instr_done      one-cycle pulse per retired instruction
//   illegal         one-cycle pulse on an unknown opcode
//   halted          high while in HALT
//   retired_count   retired instruction count, wraps
module control_sequencer #(
  parameter int unsigned INSTR_W    = 8,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned CNT_W      = 16,
  parameter logic [7:0]  HALT_INSTR = 8'hFF,
  parameter logic [3:0]  LOAD_OPC   = 4'hA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic               stall,
  input  logic               mem_ready,
  output logic [CTRL_W-1:0]  control_signals,
  output logic [2:0]         state,
  output logic [INSTR_W-1:0] instr_reg,
  output logic               instr_done,
  output logic               illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t st;

  // Decode fields of the low instruction byte; upper bits are carried only.
  logic [1:0] cls;
  logic [1:0] dest;
  logic [3:0] op;
  logic       is_nop;
  logic       is_halt;
  logic       is_load;
  logic       is_rtype;
  logic       is_otype;
  logic       is_legal;

  assign cls      = instr_reg[7:6];
  assign dest     = instr_reg[5:4];
  assign op       = instr_reg[3:0];
  assign is_nop   = (instr_reg[7:0] == 8'h00);
  assign is_halt  = (instr_reg[7:0] == HALT_INSTR);
  assign is_load  = (op == LOAD_OPC);
  assign is_rtype = op inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD};
  assign is_otype = op inside {4'h3, 4'h4, 4'h8};
  assign is_legal = is_load || is_rtype || is_otype;

  assign state = st;

  // Control word: built as 16 bits, anything above bit 15 stays zero.
  logic [15:0] ctrl16;

  always_comb begin
    ctrl16 = '0;
    if (!rst && !stall) begin
      case (st)
        S_FETCH: ctrl16 = 16'h0400;
        S_DECODE: begin
          if (!is_nop && cls == 2'b00)
            ctrl16 = 16'h0200;
        end
        S_EXECUTE: begin
          // LOAD checked first so a LOAD_OPC override always wins.
          if (is_load)
            ctrl16 = 16'h0010;
          else if (is_rtype)
            ctrl16 = {8'h00, 2'b00, cls, op};
          else if (is_otype)
            ctrl16 = {8'h00, 2'b00, (cls == 2'b00) ? 2'b00 : 2'b01, op};
          else
            ctrl16 = 16'h0000;
        end
        S_WRITEBACK: begin
          if (is_load)
            ctrl16 = 16'h0800 | {2'b00, dest, 12'h000};
          else
            ctrl16 = 16'h3880;
        end
        default: ctrl16 = 16'h0000;
      endcase
    end
  end

  always_comb begin
    control_signals        = '0;
    control_signals[15:0]  = ctrl16;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= S_FETCH;
      instr_reg     <= '0;
      instr_done    <= 1'b0;
      illegal       <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      instr_done <= 1'b0;
      illegal    <= 1'b0;
      if (st == S_HALT) begin
        halted <= 1'b1;
      end else if (!stall) begin
        case (st)
          S_FETCH: begin
            if (instr_valid) begin
              instr_reg <= instr_in;
              st        <= S_DECODE;
            end
          end
          S_DECODE: begin
            if (is_nop) begin
              st            <= S_FETCH;
              instr_done    <= 1'b1;
              retired_count <= retired_count + CNT_W'(1);
            end else if (is_halt) begin
              st            <= S_HALT;
              halted        <= 1'b1;
              instr_done    <= 1'b1;
              retired_count <= retired_count + CNT_W'(1);
            end else begin
              st <= S_EXECUTE;
            end
          end
          S_EXECUTE: begin
            if (is_load) begin
              if (mem_ready)
                st <= S_WRITEBACK;
            end else if (is_legal) begin
              st <= S_WRITEBACK;
            end else begin
              st      <= S_FETCH;
              illegal <= 1'b1;
            end
          end
          S_WRITEBACK: begin
            st            <= S_FETCH;
            instr_done    <= 1'b1;
            retired_count <= retired_count + CNT_W'(1);
          end
          default: st <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        mem_ready = 1'b0;

  logic [15:0] ctrl_a, ctrl_b;
  logic [2:0]  st_a, st_b;
  logic [7:0]  ir_a, ir_b;
  logic        done_a, done_b, ill_a, ill_b, halt_a, halt_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  control_sequencer dut_a (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .stall(stall), .mem_ready(mem_ready), .control_signals(ctrl_a),
    .state(st_a), .instr_reg(ir_a), .instr_done(done_a), .illegal(ill_a),
    .halted(halt_a), .retired_count(cnt_a)
  );

  control_sequencer #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .stall(stall), .mem_ready(mem_ready), .control_signals(ctrl_b),
    .state(st_b), .instr_reg(ir_b), .instr_done(done_b), .illegal(ill_b),
    .halted(halt_b), .retired_count(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ctrl;
    logic [2:0]  st;
    logic [7:0]  ir;
    logic        done;
    logic        ill;
    logic        halt;
    logic [15:0] cnt;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] retq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0..4 in the order FETCH..HALT, plus bookkeeping.
  int          m_phase = 0;
  logic [7:0]  m_ir = '0;
  bit          m_done = 0, m_ill = 0, m_halt = 0, m_known = 0;
  int unsigned m_cnt = 0;

  function automatic bit is_r(input logic [3:0] o);
    return o inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD};
  endfunction

  function automatic bit is_o(input logic [3:0] o);
    return o inside {4'h3, 4'h4, 4'h8};
  endfunction

  function automatic int model_ctrl(input bit r, input bit s);
    int o, c;
    o = int'(m_ir[3:0]);
    c = int'(m_ir[7:6]);
    if (r || s) return 0;
    case (m_phase)
      0: return 'h0400;
      1: return (m_ir != 8'h00 && c == 0) ? 'h0200 : 0;
      2: begin
        if (o == 'hA) return 'h0010;
        if (is_r(m_ir[3:0])) return c * 16 + o;
        if (is_o(m_ir[3:0])) return ((c != 0) ? 16 : 0) + o;
        return 0;
      end
      3: return (o == 'hA) ? ('h0800 + int'(m_ir[5:4]) * 'h1000) : 'h3880;
      default: return 0;
    endcase
  endfunction

  task automatic retire();
    m_done = 1;
    m_cnt  = m_cnt + 1;
    retq.push_back(m_ir);
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] ins,
                            input bit s, input bit mr);
    if (r) begin
      m_phase = 0; m_ir = '0; m_done = 0; m_ill = 0; m_halt = 0; m_cnt = 0;
      m_known = 1;
      return;
    end
    m_done = 0;
    m_ill  = 0;
    if (m_phase == 4 || s) return;
    case (m_phase)
      0: if (v) begin m_ir = ins; m_phase = 1; end
      1: begin
        if (m_ir == 8'h00) begin retire(); m_phase = 0; end
        else if (m_ir == 8'hFF) begin retire(); m_phase = 4; m_halt = 1; end
        else m_phase = 2;
      end
      2: begin
        if (m_ir[3:0] == 4'hA) begin
          if (mr) m_phase = 3;
        end else if (is_r(m_ir[3:0]) || is_o(m_ir[3:0])) begin
          m_phase = 3;
        end else begin
          m_ill = 1; m_phase = 0;
        end
      end
      3: begin retire(); m_phase = 0; end
      default: ;
    endcase
  endtask

  // One clock cycle of stimulus: drive, record what this cycle must show,
  // then advance the model across the coming edge.
  task automatic step(input bit r, input bit v, input logic [7:0] ins,
                      input bit s, input bit mr);
    exp_t e;
    @(negedge clk);
    rst = r; instr_valid = v; instr_in = ins; stall = s; mem_ready = mr;
    if (m_known) begin
      e.ctrl = 16'(model_ctrl(r, s));
      e.st   = 3'(m_phase);
      e.ir   = m_ir;
      e.done = m_done;
      e.ill  = m_ill;
      e.halt = m_halt;
      e.cnt  = 16'(m_cnt);
      expq.push_back(e);
    end
    model_step(r, v, ins, s, mr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic run(input logic [7:0] ins);
    step(0, 1, ins, 0, 0);
    idle(4);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output set; compare it
  // with the oldest queued expectation. Retirements are also matched
  // against the queue of retired instructions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("ctrl",    32'(ctrl_a), 32'(e.ctrl));
        chk("state",   32'(st_a),   32'(e.st));
        chk("ir",      32'(ir_a),   32'(e.ir));
        chk("done",    32'(done_a), 32'(e.done));
        chk("illegal", 32'(ill_a),  32'(e.ill));
        chk("halted",  32'(halt_a), 32'(e.halt));
        chk("count",   32'(cnt_a),  32'(e.cnt));
        chk("ctrl_b",  32'(ctrl_b), 32'(e.ctrl));
        chk("state_b", 32'(st_b),   32'(e.st));
        chk("count_b", 32'(cnt_b),  32'(e.cnt[1:0]));
        chk("done_b",  32'(done_b), 32'(e.done));
        chk("ill_b",   32'(ill_b),  32'(e.ill));
        chk("halt_b",  32'(halt_b), 32'(e.halt));
        chk("ir_b",    32'(ir_b),   32'(e.ir));
        if (done_a === 1'b1) begin
          if (retq.size() == 0)
            chk("retire_unexpected", 32'(1), 32'(0));
          else
            chk("retired_ir", 32'(ir_a), 32'(retq.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gen_instr();
    logic [7:0] x;
    x = 8'($urandom);
    case ($urandom_range(0, 19))
      0, 1:    return 8'h00;
      2:       return 8'hFF;
      3, 4, 5: return {x[7:4], 4'hA};
      6:       return {x[7:4], 4'hE};
      default: return x;
    endcase
  endfunction

  initial begin
    bit r, v, s, mr;
    // Reset
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    idle(1);
    // R-type, I-class O-type, O-type with class 11
    run(8'h45);
    run(8'h04);
    run(8'hC3);
    // LOAD with mem_ready low for 3 cycles, stall during the wait
    step(0, 1, 8'h2A, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);
    idle(2);
    step(0, 1, 8'h6A, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 0, 1);
    idle(2);
    // Stall two cycles in WRITEBACK
    step(0, 1, 8'h45, 0, 0);
    idle(2);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    idle(3);
    // NOP, illegal, then HALT with inputs ignored
    step(0, 1, 8'h00, 0, 0);
    idle(2);
    run(8'h0E);
    step(0, 1, 8'hFF, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'h45, i % 2, 1);
    step(1, 0, 8'h00, 0, 0);
    // Five retirements so the 2-bit counter wraps
    for (int i = 0; i < 5; i++) run(8'h12);
    // Reset mid-EXECUTE
    step(0, 1, 8'h45, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    idle(2);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0) || (m_phase == 4 && $urandom_range(0, 7) == 0);
      v  = $urandom_range(0, 2) != 0;
      s  = $urandom_range(0, 5) == 0;
      mr = $urandom_range(0, 2) == 0;
      step(r, v, gen_instr(), s, mr);
    end
    step(1, 0, 8'h00, 0, 0);
    run(8'h45);
    idle(3);
    @(negedge clk);
    #5;
    chk("expect_queue_drained", 32'(expq.size()), 32'(0));
    chk("retire_queue_drained", 32'(retq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
